// File: rtl/bounce_sprite.sv
// Pixel-colour stage: one bouncing solid sprite over a dim grid, RGB222 out,
// with sync outputs delayed to stay aligned with the registered colour.
module bounce_sprite #(
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int SPR_W     = 32,
  parameter int SPR_H     = 32,
  parameter int STEP_X    = 1,
  parameter int STEP_Y    = 1,
  parameter int INIT_X    = 0,
  parameter int INIT_Y    = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       display_on,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic [1:0] R,
  output logic [1:0] G,
  output logic [1:0] B,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [7:0] bounce_cnt
);

  localparam logic [10:0] HD  = 11'(H_DISPLAY);
  localparam logic [10:0] VD  = 11'(V_DISPLAY);
  localparam logic [10:0] SW  = 11'(SPR_W);
  localparam logic [10:0] SH  = 11'(SPR_H);
  localparam logic [10:0] SX  = 11'(STEP_X);
  localparam logic [10:0] SY  = 11'(STEP_Y);
  localparam logic [9:0]  IX  = 10'(INIT_X);
  localparam logic [9:0]  IY  = 10'(INIT_Y);
  localparam logic [9:0]  MAX_X = 10'(H_DISPLAY - SPR_W);
  localparam logic [9:0]  MAX_Y = 10'(V_DISPLAY - SPR_H);

  logic [9:0]  spr_x, spr_y, nx_x, nx_y;
  logic        dir_x, dir_y, nx_dx, nx_dy;
  logic        hit_x, hit_y;
  logic [1:0]  hits;
  logic [1:0]  col_idx;
  logic        vsync_prev;
  logic        tick;
  logic [10:0] x11, y11, h11, v11;
  logic        in_spr, on_grid;
  logic [5:0]  rgb_nx;

  assign x11  = {1'b0, spr_x};
  assign y11  = {1'b0, spr_y};
  assign h11  = {1'b0, hpos};
  assign v11  = {1'b0, vpos};
  assign tick = vsync_in & ~vsync_prev;

  // 11-bit sums keep the edge tests free of wrap-around
  always_comb begin
    nx_x  = spr_x;
    nx_dx = dir_x;
    hit_x = 1'b0;
    if (!dir_x) begin
      if (x11 + SX + SW > HD) begin
        nx_x  = MAX_X;
        nx_dx = 1'b1;
        hit_x = 1'b1;
      end else begin
        nx_x = 10'(x11 + SX);
      end
    end else begin
      if (x11 < SX) begin
        nx_x  = 10'd0;
        nx_dx = 1'b0;
        hit_x = 1'b1;
      end else begin
        nx_x = 10'(x11 - SX);
      end
    end
  end

  always_comb begin
    nx_y  = spr_y;
    nx_dy = dir_y;
    hit_y = 1'b0;
    if (!dir_y) begin
      if (y11 + SY + SH > VD) begin
        nx_y  = MAX_Y;
        nx_dy = 1'b1;
        hit_y = 1'b1;
      end else begin
        nx_y = 10'(y11 + SY);
      end
    end else begin
      if (y11 < SY) begin
        nx_y  = 10'd0;
        nx_dy = 1'b0;
        hit_y = 1'b1;
      end else begin
        nx_y = 10'(y11 - SY);
      end
    end
  end

  assign hits = {1'b0, hit_x} + {1'b0, hit_y};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spr_x      <= IX;
      spr_y      <= IY;
      dir_x      <= 1'b0;
      dir_y      <= 1'b0;
      col_idx    <= 2'd0;
      bounce_cnt <= 8'd0;
      vsync_prev <= 1'b1;
    end else begin
      vsync_prev <= vsync_in;
      if (tick && !pause) begin
        spr_x      <= nx_x;
        spr_y      <= nx_y;
        dir_x      <= nx_dx;
        dir_y      <= nx_dy;
        col_idx    <= col_idx + hits;
        bounce_cnt <= bounce_cnt + {6'd0, hits};
      end
    end
  end

  assign in_spr  = (h11 >= x11) && (h11 < x11 + SW) && (v11 >= y11) && (v11 < y11 + SH);
  assign on_grid = (hpos[4:0] == 5'd0) || (vpos[4:0] == 5'd0);

  always_comb begin
    rgb_nx = 6'b00_00_00;
    if (display_on) begin
      if (in_spr) begin
        case (col_idx)
          2'd0:    rgb_nx = 6'b11_11_11;
          2'd1:    rgb_nx = 6'b11_00_00;
          2'd2:    rgb_nx = 6'b00_11_00;
          default: rgb_nx = 6'b00_00_11;
        endcase
      end else if (on_grid) begin
        rgb_nx = 6'b01_01_01;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      R         <= 2'd0;
      G         <= 2'd0;
      B         <= 2'd0;
      hsync_out <= 1'b0;
      vsync_out <= 1'b0;
    end else begin
      R         <= rgb_nx[5:4];
      G         <= rgb_nx[3:2];
      B         <= rgb_nx[1:0];
      hsync_out <= hsync_in;
      vsync_out <= vsync_in;
    end
  end

endmodule

// File: tb/tb_bounce_sprite.sv
// Bench for bounce_sprite: three differently parameterised instances share
// stimulus and are checked against a per-instance behavioural model.
module tb_bounce_sprite;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hpos, vpos;
  logic       display_on, hsync_in, vsync_in, pause;
  logic [17:0] rgb_all;
  logic [2:0]  hs_all, vs_all;
  logic [23:0] cnt_all;

  int checks = 0;
  int failures = 0;

  localparam int HD = 640, VD = 480, W = 32, H = 32;
  int init_x [3] = '{0, 606, 608};
  int init_y [3] = '{0, 0, 448};
  int step_x [3] = '{1, 4, 1};
  int step_y [3] = '{1, 1, 1};

  int mx [3], my [3], mdx [3], mdy [3], mcol [3], mcnt [3];
  int mprev;

  always #5 clk = ~clk;

  bounce_sprite u_def (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .R(rgb_all[5:4]), .G(rgb_all[3:2]), .B(rgb_all[1:0]),
    .hsync_out(hs_all[0]), .vsync_out(vs_all[0]), .bounce_cnt(cnt_all[7:0]));

  bounce_sprite #(.INIT_X(606), .STEP_X(4)) u_edge (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .R(rgb_all[11:10]), .G(rgb_all[9:8]), .B(rgb_all[7:6]),
    .hsync_out(hs_all[1]), .vsync_out(vs_all[1]), .bounce_cnt(cnt_all[15:8]));

  bounce_sprite #(.INIT_X(608), .INIT_Y(448)) u_corner (
    .clk(clk), .rst_n(rst_n), .hpos(hpos), .vpos(vpos), .display_on(display_on),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .R(rgb_all[17:16]), .G(rgb_all[15:14]), .B(rgb_all[13:12]),
    .hsync_out(hs_all[2]), .vsync_out(vs_all[2]), .bounce_cnt(cnt_all[23:16]));

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mx[i] = init_x[i]; my[i] = init_y[i];
      mdx[i] = 0; mdy[i] = 0; mcol[i] = 0; mcnt[i] = 0;
    end
    mprev = 1;
  endtask

  // Expected colour as a 6-bit {R,G,B} for instance i
  function automatic int pix(input int i, input int h, input int v, input int d);
    int pal [4] = '{63, 48, 12, 3};
    if (d == 0) return 0;
    if (h >= mx[i] && h < mx[i] + W && v >= my[i] && v < my[i] + H) return pal[mcol[i]];
    if (h % 32 == 0 || v % 32 == 0) return 21;
    return 0;
  endfunction

  task automatic model_step(input int vs, input int p);
    if (vs == 1 && mprev == 0 && p == 0) begin
      for (int i = 0; i < 3; i++) begin
        int hits = 0;
        if (mdx[i] == 0) begin
          if (mx[i] + step_x[i] + W > HD) begin mx[i] = HD - W; mdx[i] = 1; hits++; end
          else mx[i] = mx[i] + step_x[i];
        end else begin
          if (mx[i] < step_x[i]) begin mx[i] = 0; mdx[i] = 0; hits++; end
          else mx[i] = mx[i] - step_x[i];
        end
        if (mdy[i] == 0) begin
          if (my[i] + step_y[i] + H > VD) begin my[i] = VD - H; mdy[i] = 1; hits++; end
          else my[i] = my[i] + step_y[i];
        end else begin
          if (my[i] < step_y[i]) begin my[i] = 0; mdy[i] = 0; hits++; end
          else my[i] = my[i] - step_y[i];
        end
        mcol[i] = (mcol[i] + hits) % 4;
        mcnt[i] = (mcnt[i] + hits) % 256;
      end
    end
    mprev = vs;
  endtask

  task automatic cycle(input int h, input int v, input int d, input int hs, input int vs, input int p);
    int exp_rgb [3];
    hpos = 10'(h); vpos = 10'(v); display_on = d[0];
    hsync_in = hs[0]; vsync_in = vs[0]; pause = p[0];
    for (int i = 0; i < 3; i++) exp_rgb[i] = pix(i, h, v, d);
    @(posedge clk); #1;
    model_step(vs, p);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rgb[%0d] h=%0d v=%0d", i, h, v), int'(rgb_all[i*6 +: 6]), exp_rgb[i]);
      chk($sformatf("cnt[%0d]", i), int'(cnt_all[i*8 +: 8]), mcnt[i]);
    end
    chk("hsync_out", int'(hs_all), hs ? 7 : 0);
    chk("vsync_out", int'(vs_all), vs ? 7 : 0);
  endtask

  task automatic frame_tick(input int high_len, input int p);
    for (int k = 0; k < high_len; k++) cycle(700, 500, 0, 0, 1, p);
    cycle(700, 500, 0, 0, 0, p);
    cycle(700, 500, 0, 0, 0, p);
  endtask

  typedef struct {
    int h; int v; int d; int exp_rgb;
  } vec_t;

  vec_t tbl [8];

  initial begin
    tbl[0] = '{0, 0, 1, 63};
    tbl[1] = '{32, 5, 1, 21};
    tbl[2] = '{40, 40, 1, 0};
    tbl[3] = '{31, 31, 1, 63};
    tbl[4] = '{32, 32, 1, 21};
    tbl[5] = '{5, 64, 1, 21};
    tbl[6] = '{10, 10, 0, 0};
    tbl[7] = '{639, 479, 1, 0};

    rst_n = 1'b0; hpos = '0; vpos = '0; display_on = 1'b0;
    hsync_in = 1'b0; vsync_in = 1'b0; pause = 1'b0;
    model_reset();
    #1;
    chk("reset rgb", int'(rgb_all), 0);
    chk("reset cnt", int'(cnt_all), 0);
    chk("reset syncs", int'({hs_all, vs_all}), 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;

    for (int t = 0; t < 8; t++) begin
      cycle(tbl[t].h, tbl[t].v, tbl[t].d, 0, 0, 0);
      chk($sformatf("table %0d", t), int'(rgb_all[5:0]), tbl[t].exp_rgb);
    end

    frame_tick(2, 0);
    chk("edge x tick1", int'(u_edge.spr_x), 608);
    chk("edge dir tick1", int'(u_edge.dir_x), 1);
    chk("edge cnt tick1", int'(cnt_all[15:8]), 1);
    cycle(620, 10, 1, 0, 0, 0);
    chk("edge colour1", int'(rgb_all[11:6]), 6'b11_00_00);
    chk("corner cnt tick1", int'(cnt_all[23:16]), 2);
    chk("corner dirs", int'({u_corner.dir_x, u_corner.dir_y}), 3);
    cycle(610, 450, 1, 0, 0, 0);
    chk("corner colour2", int'(rgb_all[17:12]), 6'b00_11_00);

    frame_tick(1, 0);
    chk("edge x tick2", int'(u_edge.spr_x), 604);
    chk("corner x tick2", int'(u_corner.spr_x), 607);
    chk("corner y tick2", int'(u_corner.spr_y), 447);

    for (int k = 3; k < 10; k++) frame_tick(1, 0);
    frame_tick(800, 0);
    chk("def x 10 ticks", int'(u_def.spr_x), 10);
    chk("def y 10 ticks", int'(u_def.spr_y), 10);
    chk("def cnt 10 ticks", int'(cnt_all[7:0]), 0);

    for (int k = 0; k < 5; k++) frame_tick(3, 1);
    chk("pause x", int'(u_def.spr_x), 10);
    chk("pause edge cnt", int'(cnt_all[15:8]), 1);
    chk("pause corner col", int'(u_corner.col_idx), 2);
    frame_tick(1, 0);
    chk("unpause x", int'(u_def.spr_x), 11);
    chk("unpause y", int'(u_def.spr_y), 11);

    cycle(15, 15, 0, 0, 0, 0);
    chk("blank over sprite", int'(rgb_all[5:0]), 0);
    cycle(700, 500, 0, 1, 0, 0);
    chk("hsync follows", int'(hs_all[0]), 1);

    for (int n = 0; n < 4000; n++) begin
      int h, v;
      if ($urandom_range(0, 1) == 1) begin
        int k = $urandom_range(0, 2);
        h = mx[k] + $urandom_range(0, W + 7) - 4;
        v = my[k] + $urandom_range(0, H + 7) - 4;
        if (h < 0) h = 0;
        if (v < 0) v = 0;
      end else begin
        h = $urandom_range(0, 1023);
        v = $urandom_range(0, 1023);
      end
      cycle(h, v, ($urandom_range(0, 7) != 0) ? 1 : 0, $urandom_range(0, 1),
            ($urandom_range(0, 3) == 0) ? 1 : 0, ($urandom_range(0, 7) == 0) ? 1 : 0);
    end

    cycle(mx[0], my[0], 1, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async rst rgb", int'(rgb_all), 0);
    chk("async rst syncs", int'({hs_all, vs_all}), 0);
    chk("async rst cnt", int'(cnt_all), 0);
    model_reset();
    vsync_in = 1'b1;
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 3; k++) cycle(700, 500, 0, 0, 1, 0);
    chk("no tick at release", int'(u_def.spr_x), 0);
    cycle(700, 500, 0, 0, 0, 0);
    cycle(700, 500, 0, 0, 1, 0);
    chk("first tick after reset", int'(u_def.spr_x), 1);
    chk("edge after reset", int'(u_edge.spr_x), 608);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
